// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the dds_gen direct digital synthesiser.
//   dds_mode_t  - waveform select encoding carried on the mode input
//   LFSR_SEED   - reset value of the optional dither LFSR
//   LFSR_TAPS   - Galois feedback mask of the optional dither LFSR
package dds_pkg;

  typedef enum logic [1:0] {
    DDS_SINE   = 2'd0,
    DDS_SQUARE = 2'd1,
    DDS_SAW    = 2'd2,
    DDS_TRI    = 2'd3
  } dds_mode_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dds_if.sv
// dds_if: control/status bundle between the register front end and dds_gen.
//   en, ftw, ftw_load, pow, mode, phase_clr   - controls (master -> slave)
//   ftw_pending, wrap, out_valid, out         - status/sample (slave -> master)
interface dds_if
  import dds_pkg::*;
#(
  parameter int ACC_W   = 40,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) ();

  logic               en;
  logic [ACC_W-1:0]   ftw;
  logic               ftw_load;
  logic [PHASE_W-1:0] pow;
  dds_mode_t          mode;
  logic               phase_clr;
  logic               ftw_pending;
  logic               wrap;
  logic               out_valid;
  logic [OUT_W-1:0]   out;

  modport master (
    output en, ftw, ftw_load, pow, mode, phase_clr,
    input  ftw_pending, wrap, out_valid, out
  );

  modport slave (
    input  en, ftw, ftw_load, pow, mode, phase_clr,
    output ftw_pending, wrap, out_valid, out
  );

endinterface

// File: rtl/dds_sine_qlut.sv
// dds_sine_qlut: quarter-wave sine ROM with quadrant mirroring and negation.
// Produces a registered offset-binary sine sample from a PHASE_W-bit phase.
//   clk, rst - clock and async active-high reset
//   en       - 0 forces the registered sample to zero
//   phase    - phase word (MSB = half select, next bit = quarter select)
//   sample   - OUT_W-bit offset-binary sine value
module dds_sine_qlut
  import dds_pkg::*;
#(
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase,
  output logic [OUT_W-1:0]   sample
);

  localparam int IDX_W = PHASE_W - 2;
  localparam int QN    = 2 ** IDX_W;
  localparam int MAG_W = OUT_W - 1;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Entries are sampled at half-step offsets so the quarter can be mirrored
  // without duplicating the peak or the zero crossing.
  function automatic logic [MAG_W-1:0] lut_entry(input int k);
    real ang;
    real amp;
    ang = (real'(k) + 0.5) * 2.0 * 3.141592653589793 / real'(2 ** PHASE_W);
    amp = real'(2 ** (OUT_W - 1) - 1) * $sin(ang);
    return MAG_W'($rtoi(amp + 0.5));
  endfunction

  logic [MAG_W-1:0] rom [QN];

  for (genvar k = 0; k < QN; k++) begin : g_rom
    assign rom[k] = lut_entry(k);
  end

  logic             quad;
  logic [IDX_W-1:0] idx;
  logic [MAG_W-1:0] mag;

  // Odd quarters read the table backwards.
  assign quad = phase[PHASE_W-2];
  assign idx  = phase[IDX_W-1:0] ^ {IDX_W{quad}};
  assign mag  = rom[idx];

  // Second half of the cycle mirrors the first about midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '0;
    end else if (!en) begin
      sample <= '0;
    end else if (phase[PHASE_W-1]) begin
      sample <= MID - OUT_W'(1) - {1'b0, mag};
    end else begin
      sample <= MID + {1'b0, mag};
    end
  end

endmodule

// File: rtl/dds_gen.sv
// dds_gen: parametrised direct digital synthesiser.
//   clk, rst - clock and async active-high reset
//   bus      - dds_if slave: en, ftw, ftw_load, pow, mode, phase_clr in;
//              ftw_pending, wrap, out_valid, out (offset binary) out
// Latency is two registers from the accumulator to out.
// Build option: define DDS_DITHER_EN to add 16-bit LFSR pre-truncation dither.
module dds_gen
  import dds_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int PHASE_W   = 8,
  parameter int OUT_W     = 8,
  parameter bit SYNC_LOAD = 1'b1
) (
  input logic    clk,
  input logic    rst,
  dds_if.slave   bus
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] ftw_pend;
  logic             pend_flag;
  logic             wrap_q;
  logic [ACC_W:0]   sum;
  logic             carry;

  assign sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry = bus.en & ~bus.phase_clr & sum[ACC_W];

  // Accumulator and tuning-word registers. In wrap-aligned mode a pending
  // word is promoted on carry-out (or on phase_clr); a load on that same
  // edge becomes the next pending word rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ftw_act   <= '0;
      ftw_pend  <= '0;
      pend_flag <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= carry;
      if (bus.phase_clr) begin
        acc <= '0;
      end else if (bus.en) begin
        acc <= sum[ACC_W-1:0];
      end
      if (SYNC_LOAD) begin
        if (pend_flag && (bus.phase_clr || carry)) begin
          ftw_act   <= ftw_pend;
          pend_flag <= 1'b0;
        end
        if (bus.ftw_load) begin
          ftw_pend  <= bus.ftw;
          pend_flag <= 1'b1;
        end
      end else begin
        if (bus.ftw_load) begin
          ftw_pend <= bus.ftw;
          ftw_act  <= bus.ftw;
        end
        pend_flag <= 1'b0;
      end
    end
  end

  assign bus.ftw_pending = pend_flag;
  assign bus.wrap        = wrap_q;

  logic [PHASE_W-1:0] phase_src;

`ifdef DDS_DITHER_EN
  localparam int DW = (ACC_W - PHASE_W > 16) ? 16 : (ACC_W - PHASE_W);
  logic [15:0] lfsr;

  // Right-shifting Galois LFSR, only stepping while the generator runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (bus.en) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  if (DW > 0) begin : g_dither
    logic [PHASE_W+DW-1:0] wide;
    assign wide = acc[ACC_W-1 -: PHASE_W+DW]
                + (bus.phase_clr ? {(PHASE_W+DW){1'b0}}
                                 : {{PHASE_W{1'b0}}, lfsr[DW-1:0]});
    assign phase_src = wide[PHASE_W+DW-1 -: PHASE_W];
  end else begin : g_no_dither
    assign phase_src = acc[ACC_W-1 -: PHASE_W];
  end
`else
  assign phase_src = acc[ACC_W-1 -: PHASE_W];
`endif

  logic [PHASE_W-1:0] p1;
  dds_mode_t          mode1;
  logic               en1;

  // S1: offset phase plus the live mode/enable it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1    <= '0;
      mode1 <= DDS_SINE;
      en1   <= 1'b0;
    end else begin
      p1    <= phase_src + bus.pow;
      mode1 <= bus.mode;
      en1   <= bus.en;
    end
  end

  logic [OUT_W-1:0]   sine_q;
  logic [OUT_W-1:0]   other_q;
  logic               valid_q;
  logic [PHASE_W-1:0] tri_w;

  dds_sine_qlut #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_sine (
    .clk    (clk),
    .rst    (rst),
    .en     (en1 && (mode1 == DDS_SINE)),
    .phase  (p1),
    .sample (sine_q)
  );

  assign tri_w = p1[PHASE_W-1] ? ~(p1 << 1) : (p1 << 1);

  // S2 for the non-sine shapes; zero whenever sine is selected so the two
  // registered paths can simply be OR-ed together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      other_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en1;
      if (!en1) begin
        other_q <= '0;
      end else begin
        case (mode1)
          DDS_SQUARE: other_q <= p1[PHASE_W-1] ? '0 : '1;
          DDS_SAW:    other_q <= p1[PHASE_W-1 -: OUT_W];
          DDS_TRI:    other_q <= tri_w[PHASE_W-1 -: OUT_W];
          default:    other_q <= '0;
        endcase
      end
    end
  end

  assign bus.out       = sine_q | other_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_dds_gen.sv
// tb_dds_gen: scoreboard bench for dds_gen. Instance dut0 runs with immediate
// tuning-word load, dut1 with wrap-aligned load; both share clk and rst.
`timescale 1ns/1ps
module tb_dds_gen;
  import dds_pkg::*;

  localparam int ACC_W   = 40;
  localparam int PHASE_W = 8;
  localparam int OUT_W   = 8;
  localparam real PI     = 3.141592653589793;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus0 ();
  dds_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus1 ();

  dds_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .SYNC_LOAD(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dds_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .SYNC_LOAD(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic       valid;
    logic [7:0] out;
    logic [7:0] p;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [39:0] m_acc, m_ftw;
  logic        m_wrap;
  logic [39:0] m1_acc, m1_act, m1_pend;
  logic        m1_pf, m1_wrap;

  // Expected sample straight from the waveform definitions.
  function automatic logic [7:0] ref_sample(input logic en, input logic [7:0] p,
                                            input logic [1:0] mode);
    int k;
    int mag;
    logic [7:0] t;
    if (!en) return 8'd0;
    case (mode)
      2'd0: begin
        k = int'(p[5:0]);
        if (p[6]) k = 63 - k;
        mag = $rtoi(127.0 * $sin((real'(k) + 0.5) * 2.0 * PI / 256.0) + 0.5);
        return p[7] ? 8'(127 - mag) : 8'(128 + mag);
      end
      2'd1: return p[7] ? 8'd0 : 8'd255;
      2'd2: return p;
      default: begin
        t = p << 1;
        if (p[7]) t = ~t;
        return t;
      end
    endcase
  endfunction

  // Advance one clock: push what the S1 stage captures this edge, update
  // both reference models, then return the expectation now visible on out.
  task automatic tick(output exp_t e);
    exp_t n;
    logic [40:0] s;
    n.valid = bus0.en;
    n.p     = m_acc[39:32] + bus0.pow;
    n.out   = ref_sample(bus0.en, n.p, bus0.mode);
    exp_q.push_back(n);
    s      = {1'b0, m_acc} + {1'b0, m_ftw};
    m_wrap = bus0.en && !bus0.phase_clr && s[40];
    if (bus0.phase_clr) m_acc = '0;
    else if (bus0.en)   m_acc = s[39:0];
    if (bus0.ftw_load)  m_ftw = bus0.ftw;
    s       = {1'b0, m1_acc} + {1'b0, m1_act};
    m1_wrap = bus1.en && !bus1.phase_clr && s[40];
    if (bus1.phase_clr) begin
      m1_acc = '0;
      if (m1_pf) begin m1_act = m1_pend; m1_pf = 1'b0; end
    end else if (bus1.en) begin
      m1_acc = s[39:0];
      if (m1_wrap && m1_pf) begin m1_act = m1_pend; m1_pf = 1'b0; end
    end
    if (bus1.ftw_load) begin m1_pend = bus1.ftw; m1_pf = 1'b1; end
    @(posedge clk);
    #1;
    bus0.ftw_load = 1'b0; bus0.phase_clr = 1'b0;
    bus1.ftw_load = 1'b0; bus1.phase_clr = 1'b0;
    e = exp_q.pop_front();
  endtask

  task automatic idle_inputs();
    bus0.en = 0; bus0.ftw = '0; bus0.ftw_load = 0; bus0.pow = '0; bus0.mode = DDS_SINE; bus0.phase_clr = 0;
    bus1.en = 0; bus1.ftw = '0; bus1.ftw_load = 0; bus1.pow = '0; bus1.mode = DDS_SINE; bus1.phase_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_acc = '0; m_ftw = '0; m_wrap = 0;
    m1_acc = '0; m1_act = '0; m1_pend = '0; m1_pf = 0; m1_wrap = 0;
    exp_q.delete();
    exp_q.push_back('{1'b0, 8'd0, 8'd0});
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    #2;
    total++;
    if ({bus0.ftw_pending, bus0.wrap, bus0.out_valid, bus0.out} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL reset_dut0: got %h want 000", {bus0.ftw_pending, bus0.wrap, bus0.out_valid, bus0.out});
    end
    total++;
    if ({bus1.ftw_pending, bus1.wrap, bus1.out_valid, bus1.out} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL reset_dut1: got %h want 000", {bus1.ftw_pending, bus1.wrap, bus1.out_valid, bus1.out});
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(e);
      total++;
      if (bus0.out !== e.out || bus0.out_valid !== e.valid) begin
        bad++;
        $display("[TB] FAIL reset_idle: got out=%0d valid=%b want out=%0d valid=%b", bus0.out, bus0.out_valid, e.out, e.valid);
      end
    end
  endtask

  task automatic test_saw();
    exp_t e;
    int wraps = 0;
    do_reset();
    bus0.mode = DDS_SAW;
    bus0.ftw = 40'h01_0000_0000;
    bus0.ftw_load = 1'b1;
    tick(e);
    bus0.en = 1'b1;
    for (int k = 2; k <= 270; k++) begin
      tick(e);
      total++;
      if (bus0.out !== e.out || bus0.out_valid !== e.valid) begin
        bad++;
        $display("[TB] FAIL saw_sample: tick %0d got out=%0d valid=%b want out=%0d valid=%b", k, bus0.out, bus0.out_valid, e.out, e.valid);
      end
      total++;
      if (bus0.wrap !== m_wrap) begin
        bad++;
        $display("[TB] FAIL saw_wrap: tick %0d got %b want %b", k, bus0.wrap, m_wrap);
      end
      if (k >= 3) begin
        total++;
        if (bus0.out !== 8'(k - 3) || bus0.out_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL saw_count: tick %0d got out=%0d valid=%b want out=%0d valid=1", k, bus0.out, bus0.out_valid, 8'(k - 3));
        end
      end
      if (bus0.wrap === 1'b1) wraps++;
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("[TB] FAIL saw_wrap_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_square();
    exp_t e;
    int high = 0;
    bus0.mode = DDS_SQUARE;
    bus0.pow = 8'h40;
    tick(e);
    tick(e);
    for (int i = 0; i < 256; i++) begin
      tick(e);
      total++;
      if (bus0.out !== e.out || bus0.out_valid !== e.valid) begin
        bad++;
        $display("[TB] FAIL square_sample: got out=%0d valid=%b want out=%0d valid=%b", bus0.out, bus0.out_valid, e.out, e.valid);
      end
      if (bus0.out === 8'd255) high++;
    end
    total++;
    if (high != 128) begin
      bad++;
      $display("[TB] FAIL square_duty: got %0d high samples want 128", high);
    end
  endtask

  task automatic test_sine();
    exp_t e;
    logic [7:0] sv [256];
    int mx = 0;
    int mn = 255;
    bus0.mode = DDS_SINE;
    bus0.pow = 8'h00;
    tick(e);
    tick(e);
    for (int i = 0; i < 256; i++) begin
      tick(e);
      total++;
      if (bus0.out !== e.out || bus0.out_valid !== e.valid) begin
        bad++;
        $display("[TB] FAIL sine_sample: p=%0d got out=%0d want out=%0d", e.p, bus0.out, e.out);
      end
      sv[e.p] = bus0.out;
      if (int'(bus0.out) > mx) mx = int'(bus0.out);
      if (int'(bus0.out) < mn) mn = int'(bus0.out);
    end
    total++;
    if (sv[0] !== 8'd130) begin
      bad++;
      $display("[TB] FAIL sine_first: got %0d want 130", sv[0]);
    end
    total++;
    if (sv[63] !== sv[64]) begin
      bad++;
      $display("[TB] FAIL sine_quarter: out[63]=%0d out[64]=%0d want equal", sv[63], sv[64]);
    end
    for (int p = 0; p < 128; p++) begin
      total++;
      if (int'(sv[p]) + int'(sv[p+128]) != 255) begin
        bad++;
        $display("[TB] FAIL sine_half: p=%0d sum=%0d want 255", p, int'(sv[p]) + int'(sv[p+128]));
      end
    end
    total++;
    if (mx != 255 || mn != 0) begin
      bad++;
      $display("[TB] FAIL sine_range: got max=%0d min=%0d want 255/0", mx, mn);
    end
  endtask

  task automatic test_random_modes();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      bus0.mode = dds_mode_t'($urandom_range(0, 3));
      bus0.pow = 8'($urandom);
      bus0.en = ($urandom_range(0, 9) != 0);
      bus0.phase_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) begin
        bus0.ftw = {8'($urandom_range(1, 7)), 32'($urandom)};
        bus0.ftw_load = 1'b1;
      end
      tick(e);
      total++;
      if (bus0.out !== e.out || bus0.out_valid !== e.valid || bus0.wrap !== m_wrap) begin
        bad++;
        $display("[TB] FAIL random_mix: got out=%0d valid=%b wrap=%b want out=%0d valid=%b wrap=%b",
                 bus0.out, bus0.out_valid, bus0.wrap, e.out, e.valid, m_wrap);
      end
    end
  endtask

  task automatic test_clear_disable();
    exp_t e;
    do_reset();
    bus0.ftw = 40'h01_0000_0000; bus0.ftw_load = 1'b1; bus0.en = 1'b1; bus0.mode = DDS_SAW;
    for (int i = 0; i < 20; i++) tick(e);
    bus0.en = 1'b0;
    bus0.phase_clr = 1'b1;
    tick(e);
    tick(e);
    total++;
    if (bus0.out !== 8'd0 || bus0.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL disable_out: got out=%0d valid=%b want 0/0", bus0.out, bus0.out_valid);
    end
    bus0.en = 1'b1;
    tick(e);
    tick(e);
    total++;
    if (bus0.out !== 8'd0 || bus0.out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear_restart: got out=%0d valid=%b want 0/1", bus0.out, bus0.out_valid);
    end
    tick(e);
    total++;
    if (bus0.out !== 8'd1 || bus0.out !== e.out) begin
      bad++;
      $display("[TB] FAIL clear_step: got out=%0d want 1", bus0.out);
    end
    // Pending word on the wrap-aligned instance is applied by phase_clr even with en low.
    bus1.ftw = 40'h02_0000_0000; bus1.ftw_load = 1'b1;
    tick(e);
    bus1.phase_clr = 1'b1;
    tick(e);
    total++;
    if (bus1.ftw_pending !== 1'b0 || m1_act !== 40'h02_0000_0000) begin
      bad++;
      $display("[TB] FAIL clear_pending: got pending=%b want 0", bus1.ftw_pending);
    end
  endtask

  // Run until the model's pending flag drops, checking the DUT every cycle.
  task automatic wait_apply(input string tag);
    exp_t e;
    int n = 0;
    while (m1_pf && n < 300) begin
      tick(e);
      n++;
      total++;
      if (bus1.ftw_pending !== m1_pf || bus1.wrap !== m1_wrap) begin
        bad++;
        $display("[TB] FAIL %s_pending: got pending=%b wrap=%b want %b/%b", tag, bus1.ftw_pending, bus1.wrap, m1_pf, m1_wrap);
      end
    end
    if (m1_pf) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: pending never applied", tag);
    end
  endtask

  task automatic check_step(input string tag, input logic [7:0] step);
    exp_t e;
    logic [7:0] prev;
    for (int i = 0; i < 3; i++) tick(e);
    prev = bus1.out;
    for (int i = 0; i < 8; i++) begin
      tick(e);
      total++;
      if (8'(bus1.out - prev) !== step) begin
        bad++;
        $display("[TB] FAIL %s_step: got %0d want %0d", tag, 8'(bus1.out - prev), step);
      end
      prev = bus1.out;
    end
  endtask

  task automatic test_sync_load();
    exp_t e;
    int n;
    do_reset();
    bus1.en = 1'b1; bus1.mode = DDS_SAW;
    bus1.ftw = 40'h01_0000_0000; bus1.ftw_load = 1'b1;
    tick(e);
    tick(e);
    total++;
    if (bus1.ftw_pending !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sync_first_pending: got %b want 1", bus1.ftw_pending);
    end
    bus1.phase_clr = 1'b1;
    tick(e);
    total++;
    if (bus1.ftw_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sync_clr_apply: got %b want 0", bus1.ftw_pending);
    end
    n = 0;
    while (m1_acc[39:32] != 8'h10 && n < 300) begin tick(e); n++; end
    bus1.ftw = 40'h02_0000_0000; bus1.ftw_load = 1'b1;
    tick(e);
    total++;
    if (bus1.ftw_pending !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sync_load_pending: got %b want 1", bus1.ftw_pending);
    end
    check_step("sync_before", 8'd1);
    wait_apply("sync_wrap");
    check_step("sync_after", 8'd2);
    bus1.ftw = 40'h03_0000_0000; bus1.ftw_load = 1'b1;
    tick(e);
    tick(e);
    bus1.ftw = 40'h05_0000_0000; bus1.ftw_load = 1'b1;
    tick(e);
    total++;
    if (bus1.ftw_pending !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sync_override_pending: got %b want 1", bus1.ftw_pending);
    end
    wait_apply("sync_override");
    check_step("sync_override", 8'd5);
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    bus0.ftw = 40'h03_0000_0000; bus0.ftw_load = 1'b1; bus0.en = 1'b1; bus0.mode = DDS_SQUARE;
    bus1.ftw = 40'h01_0000_0000; bus1.ftw_load = 1'b1; bus1.en = 1'b1;
    for (int i = 0; i < 10; i++) tick(e);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus0.ftw_pending, bus0.wrap, bus0.out_valid, bus0.out} !== 11'h0 ||
        {bus1.ftw_pending, bus1.wrap, bus1.out_valid, bus1.out} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h/%h want 000/000",
               {bus0.ftw_pending, bus0.wrap, bus0.out_valid, bus0.out},
               {bus1.ftw_pending, bus1.wrap, bus1.out_valid, bus1.out});
    end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_saw();
    test_square();
    test_sine();
    test_random_modes();
    test_clear_disable();
    test_sync_load();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_gen.md
Name: dds_gen

Overview:
- Parametrised direct digital synthesiser; next generation of the single-channel 40-bit sine DDS.
- Generalised accumulator, phase and output widths.
- Adds:
  - synchronous, clocked tuning-word load with optional wrap-aligned (phase-continuous) update
  - phase offset and phase clear
  - four waveform modes, with sine from a quarter-wave LUT
- Sits between the control register/UART front end and the output DAC pins.

Parameters:
- ACC_W, 40, phase accumulator width (bits).
- PHASE_W, 8, phase bits taken from accumulator MSBs for waveform generation; must satisfy 3 <= PHASE_W <= ACC_W.
- OUT_W, 8, output sample width; must satisfy OUT_W <= PHASE_W.
- SYNC_LOAD, 1, 1 = pending tuning word applied at next accumulator wrap; 0 = applied on the cycle after ftw_load.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator run enable; 0 freezes accumulator and forces output to 0.
- ftw  in  ACC_W  tuning word, sampled when ftw_load=1.
- ftw_load  in  1  single-cycle strobe, captures ftw.
- pow  in  PHASE_W  phase offset added to phase MSBs; live, sampled every cycle.
- mode  in  2  0=sine, 1=square, 2=sawtooth, 3=triangle; live, sampled every cycle.
- phase_clr  in  1  synchronous clear of accumulator.
- ftw_pending  out  1  captured word not yet active (SYNC_LOAD=1 only, else always 0).
- wrap  out  1  one-cycle pulse, accumulator overflowed on previous update.
- out_valid  out  1  en delayed through the output pipeline.
- out  out  OUT_W  sample, unsigned offset binary (midscale = 2^(OUT_W-1)).

Behaviour:
- Reset (async), all registers cleared:
  - acc=0, active ftw=0, pending ftw=0
  - ftw_pending=0, wrap=0, out_valid=0, out=0
- Tuning word:
  - On ftw_load, ftw is copied into the pending register.
  - SYNC_LOAD=0: pending word becomes active at that same edge; the first accumulation using it is on the next edge.
  - SYNC_LOAD=1: ftw_pending=1 until the edge where the accumulator carry-out occurs; at that edge the active word takes pending and ftw_pending clears.
  - A second ftw_load while pending overwrites the pending value; ftw_pending stays 1.
  - ftw_load coincident with a wrap edge: the new ftw becomes pending and waits for the following wrap.
- Accumulator:
  - If phase_clr: acc <= 0. If SYNC_LOAD=1 and a word is pending, it is applied immediately and ftw_pending clears. phase_clr wins over en.
  - Else if en: acc <= acc + active_ftw, modulo 2^ACC_W.
  - Else: hold.
  - wrap <= en & ~phase_clr & carry-out.
- Pipeline (latency 2 from accumulator register to out):
  - S1 registers p = acc[ACC_W-1 -: PHASE_W] + pow (mod 2^PHASE_W), plus mode and en.
  - S2 registers out and out_valid.
- Waveform, computed in S2 from the S1 registers:
  - sine:
    - q = p[PHASE_W-2]; idx = low PHASE_W-2 bits, bit-inverted when q=1; mag = LUT[idx].
    - out = p[MSB] ? mid-1-mag : mid+mag.
    - LUT has 2^(PHASE_W-2) entries: LUT[k] = round((mid-1)*sin((k+0.5)*2*pi/2^PHASE_W)), filled at elaboration.
  - square: p[MSB]=0 -> all ones, else 0.
  - saw: p[PHASE_W-1 -: OUT_W].
  - triangle: t = p[MSB] ? ~(p<<1) : (p<<1), then top OUT_W bits.
- S1 en=0 -> out=0 and out_valid=0 in S2. mode/pow changes therefore take effect on out exactly 2 cycles later.
- Reset mid-operation clears everything immediately; there is no partial-state recovery.

Optional Feature:
- DDS_DITHER_EN:
  - Defined: a 16-bit Galois LFSR (taps 0xB400, reset seed 0xACE1) advances every cycle with en=1. Its low min(16, ACC_W-PHASE_W) bits are added into the accumulator bits just below the phase field before truncation in S1 (pre-truncation dither). Dither is not added when phase_clr=1.
  - Undefined: no LFSR is instantiated; behaviour is exactly as above.

Decomposition:
- Package dds_pkg holds:
  - mode encoding enum dds_mode_t (DDS_SINE, DDS_SQUARE, DDS_SAW, DDS_TRI)
  - LFSR seed and tap constants
- One sub-module, dds_sine_qlut: quarter-wave ROM plus quadrant mirroring/negation, parameterised by PHASE_W and OUT_W, registered output (forms S2 for sine).

Test Plan:
All cases use ACC_W=40, PHASE_W=8, OUT_W=8, SYNC_LOAD=0 unless noted.
- Reset, then en=1, saw, ftw=2^32 loaded -> out_valid rises 2 cycles after first accumulation; out counts 0,1,2,...,255,0; wrap pulses once per 256 cycles.
- Square, ftw=2^32, pow=0x40 -> out=255 for 64 cycles, 0 for 128, 255 for 64, repeating.
- Sine, ftw=2^32 -> out[0]=130, quarter symmetry out[63]==out[64], out[p]+out[p+128]==255 for all p, peak 255 and trough 0 never exceeded.
- SYNC_LOAD=1 with running ftw=2^32, load 2^33 at acc phase 0x10 -> ftw_pending=1 until the wrap edge; afterwards saw steps by 2; a second load before wrap overrides the first.
- phase_clr with en=0 and a pending word -> acc=0, ftw_pending=0; en=0 keeps out=0 and out_valid=0 two cycles later; async rst mid-run zeroes all outputs without a clock edge.
